coeff_mult_stage: RTL and testbench

//  Pipelined 12x12 coefficient multiplier; sits directly upstream of modular_reduce.

---
 rtl/coeff_mult_stage.sv | 108 ++++++++++
 tb/tb_coeff_mult_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_mult_stage.sv
// coeff_mult_stage: pipelined 12x12 coefficient multiplier feeding modular_reduce,
// with output backpressure, sticky operand range check and an issued-product counter.
module coeff_mult_stage #(
    parameter  int unsigned LATENCY = 2,
    parameter  int unsigned Q       = 3329,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned CW      = 12,
    localparam int unsigned PW      = 2 * CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [CW-1:0]    a_i,
    input  logic [CW-1:0]    b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [PW-1:0]    product_o,
    output logic             range_err_o,
    input  logic             clr_i,
    output logic [CNT_W-1:0] issued_o
);

    localparam logic [CW-1:0] Q_LIM = CW'(Q);

    logic stall;
    logic accept;
    logic handoff;
    logic out_of_range;

    // Whole pipe freezes while the output is blocked; bubbles are not squeezed out.
    assign stall        = valid_o && !ready_i;
    assign ready_o      = !stall;
    assign accept       = valid_i && ready_o;
    assign handoff      = valid_o && ready_i;
    assign out_of_range = (a_i >= Q_LIM) || (b_i >= Q_LIM);

    if (LATENCY == 1) begin : g_lat1
        logic          vld_q;
        logic [PW-1:0] prod_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                prod_q <= '0;
            end else if (!stall) begin
                vld_q  <= valid_i;
                prod_q <= PW'(a_i) * PW'(b_i);
            end
        end

        assign valid_o   = vld_q;
        assign product_o = prod_q;
    end else begin : g_latn
        logic                     s1_vld;
        logic [CW-1:0]            s1_a;
        logic [CW-1:0]            s1_b;
        logic [LATENCY:2]         vld_q;
        logic [LATENCY:2][PW-1:0] prod_q;

        // Stage 1 holds operands, stage 2 the product, later stages are plain delay.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_vld <= 1'b0;
                s1_a   <= '0;
                s1_b   <= '0;
                vld_q  <= '0;
                prod_q <= '0;
            end else if (!stall) begin
                s1_vld    <= valid_i;
                s1_a      <= a_i;
                s1_b      <= b_i;
                vld_q[2]  <= s1_vld;
                prod_q[2] <= PW'(s1_a) * PW'(s1_b);
                for (int k = LATENCY; k > 2; k--) begin
                    vld_q[k]  <= vld_q[k-1];
                    prod_q[k] <= prod_q[k-1];
                end
            end
        end

        assign valid_o   = vld_q[LATENCY];
        assign product_o = prod_q[LATENCY];
    end

    // Sticky range flag; a clear in the same cycle as a new error wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err_o <= 1'b0;
        end else if (clr_i) begin
            range_err_o <= 1'b0;
        end else if (accept && out_of_range) begin
            range_err_o <= 1'b1;
        end
    end

    // Hand-off counter wraps silently; clear beats a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_o <= '0;
        end else if (clr_i) begin
            issued_o <= '0;
        end else if (handoff) begin
            issued_o <= issued_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_coeff_mult_stage.sv
// Self-checking bench for coeff_mult_stage: randomized and directed scenarios checked
// against a queue-based reference model of the accepted pairs.
module tb_coeff_mult_stage;

    localparam int unsigned LAT      = 2;
    localparam int unsigned QM       = 3329;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned CNT_MASK = (1 << CNT_W) - 1;
    localparam int unsigned N_STREAM = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, valid_o, ready_i, range_err_o, clr_i;
    logic [11:0] a_i, b_i;
    logic [23:0] product_o;
    logic [15:0] issued_o;

    logic        v2, rdy2_o, val2, rdy2_i, err2, clr2;
    logic [11:0] a2, b2;
    logic [23:0] prod2;
    logic [3:0]  iss2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned exp_q[$];
    int unsigned exp_t[$];
    bit          exp_err;
    int unsigned exp_cnt;

    int unsigned rt_v[14]   = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    int unsigned rt_a[14]   = '{3329, 0, 0, 0, 0, 0, 4095, 3328, 0, 0, 0, 0, 0, 0};
    int unsigned rt_b[14]   = '{2, 0, 0, 0, 0, 0, 1, 3328, 0, 0, 4095, 0, 0, 0};
    int unsigned rt_clr[14] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0};

    coeff_mult_stage #(.LATENCY(LAT), .Q(QM), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
        .product_o(product_o), .range_err_o(range_err_o), .clr_i(clr_i),
        .issued_o(issued_o)
    );

    coeff_mult_stage #(.LATENCY(1), .Q(QM), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .valid_i(v2), .ready_o(rdy2_o),
        .a_i(a2), .b_i(b2), .valid_o(val2), .ready_i(rdy2_i),
        .product_o(prod2), .range_err_o(err2), .clr_i(clr2),
        .issued_o(iss2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: an accepted pair becomes visible LAT edges after the sample
    // it was presented in (no-stall timing); products leave in acceptance order.
    task automatic model_edge(input bit acc, input int unsigned a, input int unsigned b,
                              input bit hand, input bit clr);
        if (acc) begin
            exp_q.push_back(a * b);
            exp_t.push_back(cyc + LAT);
        end
        if (hand && exp_q.size() > 0) begin
            exp_q.delete(0);
            exp_t.delete(0);
        end
        if (clr) begin
            exp_err = 1'b0;
            exp_cnt = 0;
        end else begin
            if (acc && (a >= QM || b >= QM)) exp_err = 1'b1;
            if (hand) exp_cnt = (exp_cnt + 1) & CNT_MASK;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b1; a_i = 12'd5; b_i = 12'd7; ready_i = 1'b1; clr_i = 1'b0;
        v2 = 1'b0; a2 = '0; b2 = '0; rdy2_i = 1'b1; clr2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
            n_checks++; if (issued_o !== 16'd0) begin n_fail++; $display("FAIL reset_issued: got %0d want 0", issued_o); end
            n_checks++; if (range_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", range_err_o); end
            n_checks++; if (product_o !== 24'd0) begin n_fail++; $display("FAIL reset_product: got %0d want 0", product_o); end
            n_checks++; if (val2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid_w4: got %0b want 0", val2); end
        end
        @(negedge clk);
        valid_i = 1'b0;
        rst_n   = 1'b1;
        exp_err = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_single();
        bit exp_v;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_i = (i == 0); a_i = 12'd3328; b_i = 12'd3328; ready_i = 1'b1;
            #1;
            exp_v = exp_q.size() > 0 && cyc >= exp_t[0];
            n_checks++; if (valid_o !== exp_v) begin n_fail++; $display("FAIL single_valid[%0d]: got %0b want %0b", i, valid_o, exp_v); end
            if (exp_v) begin
                n_checks++; if (product_o !== 24'd11075584) begin n_fail++; $display("FAIL single_product: got %0d want 11075584", product_o); end
                n_checks++; if ((32'(product_o) % QM) !== 1) begin n_fail++; $display("FAIL single_modq: got %0d want 1", 32'(product_o) % QM); end
            end
            model_edge(valid_i && ready_o, 32'(a_i), 32'(b_i), valid_o && ready_i, 1'b0);
        end
        n_checks++; if (issued_o !== 16'd1) begin n_fail++; $display("FAIL single_issued: got %0d want 1", issued_o); end
    endtask

    task automatic test_stream();
        bit exp_v;
        @(negedge clk);
        clr_i = 1'b1; valid_i = 1'b0;
        #1;
        model_edge(1'b0, 0, 0, valid_o && ready_i, 1'b1);
        for (int i = 0; i < N_STREAM + LAT + 2; i++) begin
            @(negedge clk);
            clr_i = 1'b0; ready_i = 1'b1; valid_i = (i < N_STREAM);
            a_i = 12'($urandom_range(3328, 0));
            b_i = 12'($urandom_range(3328, 0));
            #1;
            n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %0b want 1", i, ready_o); end
            exp_v = exp_q.size() > 0 && cyc >= exp_t[0];
            n_checks++; if (valid_o !== exp_v) begin n_fail++; $display("FAIL stream_valid[%0d]: got %0b want %0b", i, valid_o, exp_v); end
            if (exp_v) begin
                n_checks++; if (product_o !== 24'(exp_q[0])) begin n_fail++; $display("FAIL stream_product[%0d]: got %0d want %0d", i, product_o, exp_q[0]); end
            end
            n_checks++; if (issued_o !== 16'(exp_cnt)) begin n_fail++; $display("FAIL stream_issued[%0d]: got %0d want %0d", i, issued_o, exp_cnt); end
            model_edge(valid_i && ready_o, 32'(a_i), 32'(b_i), valid_o && ready_i, 1'b0);
        end
        @(negedge clk); #1;
        n_checks++; if (issued_o !== 16'(N_STREAM)) begin n_fail++; $display("FAIL stream_total: got %0d want %0d", issued_o, N_STREAM); end
        n_checks++; if (range_err_o !== 1'b0) begin n_fail++; $display("FAIL stream_err: got %0b want 0", range_err_o); end
    endtask

    task automatic test_backpressure();
        int unsigned idx = 0;
        int unsigned out_k = 0;
        bit          prev_stall = 1'b0;
        logic [23:0] prev_prod = '0;
        bit          exp_rdy;
        for (int i = 0; i < 40 && out_k < 10; i++) begin
            @(negedge clk);
            ready_i = !(i >= 5 && i < 8);
            valid_i = (idx < 10);
            a_i = 12'(idx); b_i = 12'(idx + 1);
            #1;
            exp_rdy = !(i >= 5 && i < 8);
            n_checks++; if (ready_o !== exp_rdy) begin n_fail++; $display("FAIL bp_ready[%0d]: got %0b want %0b", i, ready_o, exp_rdy); end
            if (prev_stall) begin
                n_checks++; if (valid_o !== 1'b1 || product_o !== prev_prod) begin n_fail++; $display("FAIL bp_hold[%0d]: got %0d want %0d", i, product_o, prev_prod); end
            end
            if (valid_o && ready_i) begin
                n_checks++; if (product_o !== 24'(out_k * (out_k + 1))) begin n_fail++; $display("FAIL bp_product[%0d]: got %0d want %0d", out_k, product_o, out_k * (out_k + 1)); end
                out_k++;
            end
            prev_stall = valid_o && !ready_i;
            prev_prod  = product_o;
            if (valid_i && ready_o) idx++;
            model_edge(valid_i && ready_o, 32'(a_i), 32'(b_i), valid_o && ready_i, 1'b0);
        end
        n_checks++; if (out_k !== 10) begin n_fail++; $display("FAIL bp_count: got %0d products want 10", out_k); end
        ready_i = 1'b1;
    endtask

    task automatic test_range();
        bit exp_v;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            valid_i = rt_v[i][0]; a_i = 12'(rt_a[i]); b_i = 12'(rt_b[i]);
            clr_i = rt_clr[i][0]; ready_i = 1'b1;
            #1;
            exp_v = exp_q.size() > 0 && cyc >= exp_t[0];
            n_checks++; if (valid_o !== exp_v) begin n_fail++; $display("FAIL range_valid[%0d]: got %0b want %0b", i, valid_o, exp_v); end
            if (exp_v) begin
                n_checks++; if (product_o !== 24'(exp_q[0])) begin n_fail++; $display("FAIL range_product[%0d]: got %0d want %0d", i, product_o, exp_q[0]); end
            end
            if (i == 2) begin
                n_checks++; if (product_o !== 24'd6658) begin n_fail++; $display("FAIL range_6658: got %0d want 6658", product_o); end
            end
            n_checks++; if (range_err_o !== exp_err) begin n_fail++; $display("FAIL range_err[%0d]: got %0b want %0b", i, range_err_o, exp_err); end
            n_checks++; if (issued_o !== 16'(exp_cnt)) begin n_fail++; $display("FAIL range_issued[%0d]: got %0d want %0d", i, issued_o, exp_cnt); end
            model_edge(valid_i && ready_o, 32'(a_i), 32'(b_i), valid_o && ready_i, clr_i);
        end
        clr_i = 1'b0;
    endtask

    task automatic test_async_reset();
        bit exp_v;
        @(negedge clk);
        valid_i = 1'b1; a_i = 12'd100; b_i = 12'd200; ready_i = 1'b1;
        @(negedge clk);
        a_i = 12'd300; b_i = 12'd400;
        @(posedge clk); #1;
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1 || product_o !== 24'd20000) begin n_fail++; $display("FAIL arst_pre: got %0b/%0d want 1/20000", valid_o, product_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b want 0", valid_o); end
        n_checks++; if (product_o !== 24'd0) begin n_fail++; $display("FAIL arst_product: got %0d want 0", product_o); end
        n_checks++; if (issued_o !== 16'd0 || range_err_o !== 1'b0) begin n_fail++; $display("FAIL arst_status: got %0d/%0b want 0/0", issued_o, range_err_o); end
        exp_q.delete(); exp_t.delete(); exp_cnt = 0; exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            valid_i = (i == 1); a_i = 12'd7; b_i = 12'd9;
            #1;
            exp_v = exp_q.size() > 0 && cyc >= exp_t[0];
            n_checks++; if (valid_o !== exp_v) begin n_fail++; $display("FAIL arst_after_valid[%0d]: got %0b want %0b", i, valid_o, exp_v); end
            if (exp_v) begin
                n_checks++; if (product_o !== 24'd63) begin n_fail++; $display("FAIL arst_after_product: got %0d want 63", product_o); end
            end
            model_edge(valid_i && ready_o, 32'(a_i), 32'(b_i), valid_o && ready_i, 1'b0);
        end
        n_checks++; if (issued_o !== 16'd1) begin n_fail++; $display("FAIL arst_after_issued: got %0d want 1", issued_o); end
    endtask

    task automatic test_wrap();
        bit          prev_v = 1'b0;
        int unsigned prev_p = 0;
        int unsigned cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            v2 = (i < 17); rdy2_i = 1'b1;
            a2 = 12'($urandom_range(4095, 0));
            b2 = 12'($urandom_range(4095, 0));
            #1;
            n_checks++; if (val2 !== prev_v) begin n_fail++; $display("FAIL wrap_valid[%0d]: got %0b want %0b", i, val2, prev_v); end
            if (prev_v) begin
                n_checks++; if (prod2 !== 24'(prev_p)) begin n_fail++; $display("FAIL wrap_product[%0d]: got %0d want %0d", i, prod2, prev_p); end
            end
            n_checks++; if (iss2 !== 4'(cnt)) begin n_fail++; $display("FAIL wrap_issued[%0d]: got %0d want %0d", i, iss2, cnt); end
            if (val2 && rdy2_i) cnt = (cnt + 1) % 16;
            prev_v = v2 && rdy2_o;
            prev_p = 32'(a2) * 32'(b2);
        end
        n_checks++; if (iss2 !== 4'd1) begin n_fail++; $display("FAIL wrap_final: got %0d want 1", iss2); end
        v2 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_range();
        test_async_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
